// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared port constants and types for the NoC switch allocator
package noc_pkg;

    localparam int NPORTS          = 5;
    localparam int PORT_NORTH      = 0;
    localparam int PORT_SOUTH      = 1;
    localparam int PORT_EAST       = 2;
    localparam int PORT_WEST       = 3;
    localparam int PORT_LOCAL      = 4;
    localparam int CREDITS_DEFAULT = 4;

    typedef logic [2:0] port_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - five-way round-robin pick, searching upward from ptr
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  port_addr_t        ptr,
    output logic [NPORTS-1:0] grant,
    output port_addr_t        winner
);

    logic [3:0] idx;
    logic       found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NPORTS)) begin
                idx = idx - 4'(NPORTS);
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx[2:0];
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output wormhole switch allocation with credit flow control
module switch_allocator
    import noc_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req_valid_i,
    input  logic [14:0] req_port_i,
    input  logic [4:0]  req_tail_i,
    input  logic [4:0]  credit_incr_i,
    output logic [4:0]  pop_o,
    output logic [4:0]  out_valid_o,
    output logic [14:0] xbar_sel_o,
    output logic [4:0]  locked_o,
    output logic        err_o
);

    logic [NPORTS-1:0] locked_q;
    port_addr_t        owner_q  [NPORTS];
    port_addr_t        rr_ptr_q [NPORTS];
    logic [3:0]        credit_q [NPORTS];
    logic              err_q;

    logic [NPORTS-1:0] req_mat   [NPORTS];
    logic [NPORTS-1:0] arb_grant [NPORTS];
    port_addr_t        arb_win   [NPORTS];
    logic [NPORTS-1:0] grant     [NPORTS];
    port_addr_t        win       [NPORTS];
    logic              bad_port;

    // Requests to addresses 5..7 never reach any output's request vector.
    always_comb begin
        bad_port = 1'b0;
        for (int o = 0; o < NPORTS; o++) begin
            req_mat[o] = '0;
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (req_valid_i[i]) begin
                if (req_port_i[3*i +: 3] >= port_addr_t'(NPORTS)) begin
                    bad_port = 1'b1;
                end else begin
                    req_mat[req_port_i[3*i +: 3]][i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_arb
        rr_arbiter u_arb (
            .req    (req_mat[g]),
            .ptr    (rr_ptr_q[g]),
            .grant  (arb_grant[g]),
            .winner (arb_win[g])
        );
    end

    always_comb begin
        pop_o       = '0;
        out_valid_o = '0;
        xbar_sel_o  = '0;
        for (int o = 0; o < NPORTS; o++) begin
            grant[o] = '0;
            win[o]   = '0;
            if (!rst && credit_q[o] != 4'd0) begin
                if (locked_q[o]) begin
                    if (req_mat[o][owner_q[o]]) begin
                        grant[o][owner_q[o]] = 1'b1;
                        win[o]               = owner_q[o];
                    end
                end else begin
                    grant[o] = arb_grant[o];
                    win[o]   = arb_win[o];
                end
            end
            pop_o          = pop_o | grant[o];
            out_valid_o[o] = |grant[o];
            if (out_valid_o[o]) begin
                xbar_sel_o[3*o +: 3] = win[o];
            end
        end
    end

    assign locked_o = locked_q;
    assign err_o    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= '0;
            err_q    <= 1'b0;
            for (int o = 0; o < NPORTS; o++) begin
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
                credit_q[o] <= 4'(CREDITS);
            end
        end else begin
            if (bad_port) begin
                err_q <= 1'b1;
            end
            for (int o = 0; o < NPORTS; o++) begin
                if (out_valid_o[o]) begin
                    if (locked_q[o]) begin
                        if (req_tail_i[win[o]]) begin
                            locked_q[o] <= 1'b0;
                        end
                    end else begin
                        rr_ptr_q[o] <= (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
                        if (!req_tail_i[win[o]]) begin
                            locked_q[o] <= 1'b1;
                            owner_q[o]  <= win[o];
                        end
                    end
                end
                // Simultaneous grant and return cancel out.
                if (credit_incr_i[o] && !out_valid_o[o]) begin
                    if (credit_q[o] == 4'(CREDITS)) begin
                        err_q <= 1'b1;
                    end else begin
                        credit_q[o] <= credit_q[o] + 4'd1;
                    end
                end else if (out_valid_o[o] && !credit_incr_i[o]) begin
                    credit_q[o] <= credit_q[o] - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and randomized checks against a behavioural allocator model
module tb_switch_allocator;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid_i;
    logic [14:0] req_port_i;
    logic [4:0]  req_tail_i;
    logic [4:0]  credit_incr_i;
    logic [4:0]  pop_o;
    logic [4:0]  out_valid_o;
    logic [14:0] xbar_sel_o;
    logic [4:0]  locked_o;
    logic        err_o;

    switch_allocator #(.CREDITS(C)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_port_i    (req_port_i),
        .req_tail_i    (req_tail_i),
        .credit_incr_i (credit_incr_i),
        .pop_o         (pop_o),
        .out_valid_o   (out_valid_o),
        .xbar_sel_o    (xbar_sel_o),
        .locked_o      (locked_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: owner -1 means the output is idle.
    int m_credit [5];
    int m_owner  [5];
    int m_rr     [5];
    int m_win    [5];
    bit m_err;
    logic [4:0] last_pop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pk(input int p0, input int p1, input int p2, input int p3, input int p4);
        logic [2:0] a0, a1, a2, a3, a4;
        a0 = 3'(p0); a1 = 3'(p1); a2 = 3'(p2); a3 = 3'(p3); a4 = 3'(p4);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic model_reset();
        m_err = 1'b0;
        for (int o = 0; o < 5; o++) begin
            m_credit[o] = C;
            m_owner[o]  = -1;
            m_rr[o]     = 0;
        end
    endtask

    function automatic bit wants(input logic [4:0] v, input logic [14:0] p, input int i, input int o);
        return v[i] && (int'(p[3*i +: 3]) == o);
    endfunction

    task automatic model_comb(input logic [4:0] v, input logic [14:0] p, input logic r);
        for (int o = 0; o < 5; o++) begin
            m_win[o] = -1;
            if (!r && m_credit[o] > 0) begin
                if (m_owner[o] >= 0) begin
                    if (wants(v, p, m_owner[o], o)) m_win[o] = m_owner[o];
                end else begin
                    for (int k = 0; k < 5; k++) begin
                        int i;
                        i = (m_rr[o] + k) % 5;
                        if (m_win[o] < 0 && wants(v, p, i, o)) m_win[o] = i;
                    end
                end
            end
        end
    endtask

    task automatic model_seq(input logic [4:0] v, input logic [14:0] p, input logic [4:0] t,
                             input logic [4:0] ci, input logic r);
        if (r) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 5; i++) begin
            if (v[i] && int'(p[3*i +: 3]) >= 5) m_err = 1'b1;
        end
        for (int o = 0; o < 5; o++) begin
            int w;
            w = m_win[o];
            if (w >= 0) begin
                if (m_owner[o] >= 0) begin
                    if (t[w]) m_owner[o] = -1;
                end else begin
                    m_rr[o] = (w + 1) % 5;
                    if (!t[w]) m_owner[o] = w;
                end
            end
            if (ci[o] && w < 0) begin
                if (m_credit[o] == C) m_err = 1'b1;
                else m_credit[o]++;
            end else if (!ci[o] && w >= 0) begin
                m_credit[o]--;
            end
        end
    endtask

    task automatic step(input logic [4:0] v, input logic [14:0] p, input logic [4:0] t,
                        input logic [4:0] ci, input logic r);
        logic [4:0]  e_pop, e_ov, e_lk;
        logic [14:0] e_sel;
        req_valid_i   = v;
        req_port_i    = p;
        req_tail_i    = t;
        credit_incr_i = ci;
        rst           = r;
        #1;
        model_comb(v, p, r);
        e_pop = '0; e_ov = '0; e_sel = '0; e_lk = '0;
        for (int o = 0; o < 5; o++) begin
            if (m_win[o] >= 0) begin
                e_pop[m_win[o]]  = 1'b1;
                e_ov[o]          = 1'b1;
                e_sel[3*o +: 3]  = 3'(m_win[o]);
            end
            e_lk[o] = (m_owner[o] >= 0);
        end
        check("pop", 32'(pop_o), 32'(e_pop));
        check("out_valid", 32'(out_valid_o), 32'(e_ov));
        check("xbar_sel", 32'(xbar_sel_o), 32'(e_sel));
        check("locked", 32'(locked_o), 32'(e_lk));
        check("err", 32'(err_o), 32'(m_err));
        last_pop = pop_o;
        @(posedge clk);
        model_seq(v, p, t, ci, r);
        #1;
    endtask

    task automatic do_reset();
        step('0, '0, '0, '0, 1'b1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; req_valid_i = '0; req_port_i = '0; req_tail_i = '0; credit_incr_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Three tail-only requesters to local rotate in order 0,1,3.
        do_reset();
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        step(5'b01011, pk(4, 4, 0, 4, 0), 5'b11111, '0, 1'b0);
        check("rr_c0", 32'(last_pop), 32'b00001);
        step(5'b01010, pk(4, 4, 0, 4, 0), 5'b11111, '0, 1'b0);
        check("rr_c1", 32'(last_pop), 32'b00010);
        step(5'b01000, pk(4, 4, 0, 4, 0), 5'b11111, '0, 1'b0);
        check("rr_c2", 32'(last_pop), 32'b01000);
        step(5'b10001, pk(4, 4, 0, 4, 4), 5'b11111, '0, 1'b0);
        check("rr_ptr4", 32'(last_pop), 32'b10000);

        // Three-flit packet from input 2 holds south against input 0.
        do_reset();
        step(5'b00100, pk(1, 0, 1, 0, 0), 5'b00000, '0, 1'b0);
        check("pkt_c0", 32'(last_pop), 32'b00100);
        check("lock_c0", 32'(locked_o[1]), 32'd1);
        step(5'b00101, pk(1, 0, 1, 0, 0), 5'b00000, '0, 1'b0);
        check("pkt_c1", 32'(last_pop), 32'b00100);
        check("lock_c1", 32'(locked_o[1]), 32'd1);
        step(5'b00101, pk(1, 0, 1, 0, 0), 5'b00100, '0, 1'b0);
        check("pkt_c2", 32'(last_pop), 32'b00100);
        check("lock_c2", 32'(locked_o[1]), 32'd0);
        step(5'b00001, pk(1, 0, 1, 0, 0), 5'b00001, '0, 1'b0);
        check("pkt_c3", 32'(last_pop), 32'b00001);

        // Credit exhaustion and a single credit return.
        do_reset();
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            step(5'b10000, pk(0, 0, 0, 0, 0), 5'b10000, '0, 1'b0);
            cnt += last_pop[4];
        end
        check("credit_drain", 32'(cnt), 32'd4);
        step(5'b10000, pk(0, 0, 0, 0, 0), 5'b10000, 5'b00001, 1'b0);
        cnt = last_pop[4];
        for (int n = 0; n < 3; n++) begin
            step(5'b10000, pk(0, 0, 0, 0, 0), 5'b10000, '0, 1'b0);
            cnt += last_pop[4];
        end
        check("credit_one", 32'(cnt), 32'd1);
        step(5'b10000, pk(0, 0, 0, 0, 0), 5'b10000, 5'b00001, 1'b0);
        check("credit_zero_blk", 32'(last_pop), 32'd0);
        step(5'b10000, pk(0, 0, 0, 0, 0), 5'b10000, 5'b00001, 1'b0);
        check("credit_inc_dec", 32'(last_pop), 32'b10000);
        step(5'b10000, pk(0, 0, 0, 0, 0), 5'b10000, '0, 1'b0);
        check("credit_stay1", 32'(last_pop), 32'b10000);
        for (int n = 0; n < 4; n++) step('0, '0, '0, 5'b00001, 1'b0);
        check("credit_full_noerr", 32'(err_o), 32'd0);
        step('0, '0, '0, 5'b00001, 1'b0);
        check("credit_ovf_err", 32'(err_o), 32'd1);

        // Illegal port address.
        do_reset();
        step(5'b00010, pk(0, 6, 0, 0, 0), 5'b00010, '0, 1'b0);
        check("badport_pop", 32'(last_pop), 32'd0);
        check("badport_err", 32'(err_o), 32'd1);

        // Reset in the middle of a packet.
        do_reset();
        step(5'b00100, pk(0, 0, 3, 0, 0), 5'b00000, '0, 1'b0);
        check("mid_lock", 32'(locked_o[3]), 32'd1);
        step(5'b00101, pk(3, 0, 3, 0, 0), 5'b00000, '0, 1'b1);
        check("rst_pop", 32'(last_pop), 32'd0);
        check("rst_unlock", 32'(locked_o), 32'd0);
        step(5'b00101, pk(3, 0, 3, 0, 0), 5'b00101, '0, 1'b0);
        check("post_rst", 32'(last_pop), 32'b00001);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [14:0] p;
            for (int i = 0; i < 5; i++) begin
                p[3*i +: 3] = ($urandom_range(0, 19) == 0) ? 3'(5 + $urandom_range(0, 2))
                                                           : 3'($urandom_range(0, 4));
            end
            step(5'($urandom), p, 5'($urandom), 5'($urandom & $urandom),
                 ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
